// File: rtl/jt51_pkg.sv
// Shared constants and helpers for the JT51 channel-register write queue.
package jt51_pkg;

   localparam logic [7:0] CH_BASE = 8'h20;
   localparam logic [7:0] OFS_RL  = 8'h20;
   localparam logic [7:0] OFS_KC  = 8'h28;
   localparam logic [7:0] OFS_KF  = 8'h30;
   localparam logic [7:0] OFS_PMS = 8'h38;

   localparam int DEFAULT_DEPTH = 4;

   // One queue entry is {addr[4:0], data[7:0]}
   localparam int ENTRY_W = 13;

   typedef enum logic [1:0] {
      GRP_RL  = 2'd0,
      GRP_KC  = 2'd1,
      GRP_KF  = 2'd2,
      GRP_PMS = 2'd3
   } grp_e;

   // Channel registers occupy the 0x20-0x3F window
   function automatic logic is_ch_addr(input logic [7:0] a);
      return a[7:5] == CH_BASE[7:5];
   endfunction

   // Register group from the low five address bits
   function automatic grp_e grp_of(input logic [4:0] low);
      grp_e g;
      g = GRP_RL;
      if (low[4:3] == OFS_RL[4:3])
         g = GRP_RL;
      else if (low[4:3] == OFS_KC[4:3])
         g = GRP_KC;
      else if (low[4:3] == OFS_KF[4:3])
         g = GRP_KF;
      else if (low[4:3] == OFS_PMS[4:3])
         g = GRP_PMS;
      return g;
   endfunction

   // One-hot strobe vector ordered {pms, kf, kc, rl}
   function automatic logic [3:0] grp_strobe(input grp_e g);
      logic [3:0] s;
      s = 4'b0000;
      case (g)
         GRP_RL:  s = 4'b0001;
         GRP_KC:  s = 4'b0010;
         GRP_KF:  s = 4'b0100;
         GRP_PMS: s = 4'b1000;
         default: s = 4'b0000;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/jt51_ch_wrq_if.sv
// CPU write port and channel-update outputs of the write queue.
interface jt51_ch_wrq_if;
   logic       cen;
   logic       wr_n;
   logic       a0;
   logic [7:0] din;
   logic [7:0] dout;
   logic [2:0] up_ch;
   logic       up_rl;
   logic       up_kc;
   logic       up_kf;
   logic       up_pms;
   logic       busy;
   logic       ovf;

   modport master (
      output cen, wr_n, a0, din,
      input  dout, up_ch, up_rl, up_kc, up_kf, up_pms, busy, ovf
   );

   modport slave (
      input  cen, wr_n, a0, din,
      output dout, up_ch, up_rl, up_kc, up_kf, up_pms, busy, ovf
   );
endinterface

// File: rtl/jt51_ch_fifo.sv
// Write-queue storage: power-of-two FIFO with combinational head output.
module jt51_ch_fifo
   import jt51_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int W     = ENTRY_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   // A pop frees a slot, so a full queue still takes a push in the same cycle
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage array is not reset; only the pointers define valid contents
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally modulo DEPTH, count tracks occupancy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/jt51_ch_wrq.sv
// Channel register write queue: decodes CPU writes to 0x20-0x3F, buffers
// them, and replays one per clock-enable as a single-cycle group strobe.
module jt51_ch_wrq
   import jt51_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic         clk,
   input  logic         rst_n,
   jt51_ch_wrq_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [7:0]         addr;
   logic               push;
   logic               pop;
   logic               full;
   logic [ENTRY_W-1:0] fifo_q;
   logic [CW-1:0]      count;
   logic [7:0]         dout_r;
   logic [2:0]         ch_r;
   logic [3:0]         stb_r;
   logic [3:0]         stb_nx;
   logic               ovf_r;

   // Pop looks at the registered count, so a fresh push never pops the same cycle
   assign push = !bus.wr_n && bus.a0 && is_ch_addr(addr);
   assign pop  = bus.cen && (count != '0);
   assign full = (count == CW'(DEPTH));

   // Address latch written by a0=0 accesses
   always_ff @(posedge clk) begin
      if (!rst_n)
         addr <= 8'h00;
      else if (!bus.wr_n && !bus.a0)
         addr <= bus.din;
   end

   jt51_ch_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   ({addr[4:0], bus.din}),
      .dout  (fifo_q),
      .count (count)
   );

   // Group strobe for the entry leaving the queue this cycle
   always_comb begin
      stb_nx = 4'b0000;
      if (pop)
         stb_nx = grp_strobe(grp_of(fifo_q[12:8]));
   end

   // Strobes last one cycle; data and channel hold until the next pop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stb_r  <= 4'b0000;
         dout_r <= 8'h00;
         ch_r   <= 3'd0;
      end else begin
         stb_r <= stb_nx;
         if (pop) begin
            dout_r <= fifo_q[7:0];
            ch_r   <= fifo_q[10:8];
         end
      end
   end

   // Sticky overflow: a push lost because the queue was full with no pop
   always_ff @(posedge clk) begin
      if (!rst_n)
         ovf_r <= 1'b0;
      else if (push && full && !pop)
         ovf_r <= 1'b1;
   end

   assign bus.dout   = dout_r;
   assign bus.up_ch  = ch_r;
   assign bus.up_rl  = stb_r[0];
   assign bus.up_kc  = stb_r[1];
   assign bus.up_kf  = stb_r[2];
   assign bus.up_pms = stb_r[3];
   assign bus.busy   = (count != '0);
   assign bus.ovf    = ovf_r;
endmodule

// File: doc/jt51_ch_wrq.md
JT51_CH_WRQ -- requirements
Module: jt51_ch_wrq

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the write-queue depth in entries; legal values are 2, 4 and 8.
REQ-002 clk  input  1  is the sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-004 cen  input  1  is the clock enable; drain SHALL advance only on cycles with cen=1.
REQ-005 wr_n  input  1  is the CPU write strobe, active-low, one clk cycle per access.
REQ-006 a0  input  1  selects the target: 0 writes the address latch, 1 writes data.
REQ-007 din  input  8  carries CPU write data.
REQ-008 dout  output  8  carries data for the channel register file.
REQ-009 up_ch  output  3  carries the target channel number.
REQ-010 up_rl, up_kc, up_kf, up_pms  output  1 each  are the register-group update strobes.
REQ-011 busy  output  1  is high while the queue holds at least one entry.
REQ-012 ovf  output  1  is a sticky overflow flag.

Function
REQ-013 A write with a0=0 SHALL load din into an 8-bit address latch.
REQ-014 A write with a0=1 SHALL push {addr[4:0], din} when the latched address is 0x20-0x3F; other addresses SHALL be ignored.
REQ-015 The queue SHALL be first-in first-out, and a pushed entry SHALL become poppable on the next clk.
REQ-016 When cen=1 and the queue is non-empty at a clk edge, the block SHALL pop one entry.
REQ-017 On the clk following a pop, exactly one strobe SHALL be high for exactly one clk cycle, with dout=data and up_ch=addr[2:0].
REQ-018 Strobe decode from addr[4:3] SHALL be: 00 -> up_rl, 01 -> up_kc, 10 -> up_kf, 11 -> up_pms.
REQ-019 Strobes SHALL be low in every other cycle, including cycles with cen=0.
REQ-020 dout and up_ch SHALL hold their last values between pops.
REQ-021 Minimum latency SHALL be two clk edges from the data write to the strobe, given cen=1 on the clock after the push.
REQ-022 A push to a full queue SHALL be dropped and SHALL set ovf.
REQ-023 ovf SHALL clear only on reset.
REQ-024 A simultaneous push and pop on a full queue SHALL accept the push, with no overflow.
REQ-025 A simultaneous push and pop on a one-entry queue SHALL pop the old entry and keep the new one.
REQ-026 A push to an empty queue SHALL NOT pop in the same cycle.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH, and the occupancy count SHALL be log2(DEPTH)+1 bits wide.
REQ-028 busy SHALL equal (count != 0), taken from a register.

Reset
REQ-029 With rst_n=0 at a clk edge, the block SHALL set: count=0, both pointers=0, address latch=0x00, dout=0, up_ch=0, all strobes=0, busy=0, ovf=0.
REQ-030 A reset during draining SHALL discard all queued entries, and no strobe SHALL follow in the next cycle.
REQ-031 Reset SHALL take priority over cen, over pushes and over pops.

Structure
REQ-032 The shared package jt51_pkg SHALL hold the channel address base (0x20), the group offsets (0x20/0x28/0x30/0x38) and the default DEPTH.
REQ-033 Queue storage and pointers SHALL be one sub-module, jt51_ch_fifo (push, pop, data in/out, count), with no output registers.
REQ-034 Decode, pop control and strobe generation SHALL reside in jt51_ch_wrq.

Verification
REQ-035 Bench scenario: addr 0x2A, data 0x55, cen=1 constantly -> up_kc pulses one cycle, 2 clk after the data write, with up_ch=2 and dout=0x55.
REQ-036 Bench scenario: cen=1 every 4th clk, writes 0x20<-0xC7, 0x38<-0x31, 0x30<-0xFC back-to-back -> up_rl, then up_pms, then up_kf pulse at successive cen cycles; ch=0 each, dout=0xC7/0x31/0xFC; busy falls after the third pop.
REQ-037 Bench scenario: cen=0, five data writes with DEPTH=4 -> the first four are queued, the fifth is dropped, ovf=1; after cen resumes, exactly four strobes appear.
REQ-038 Bench scenario: full queue, push in the same cycle as a pop (cen=1) -> ovf stays 0 and count stays 4.
REQ-039 Bench scenario: addr 0x1F or 0x40 data writes -> no push and busy stays 0.
REQ-040 Bench scenario: rst_n=0 for 1 clk with 3 entries queued -> busy=0, ovf=0, no strobes for 10 cycles with cen=1.
